// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg -- shared definitions for the sequential signed divider.
//
// Contents:
//   DIV_WIDTH   : operand/result width (32)
//   DIV_CNT_W   : iteration counter width, clog2(DIV_WIDTH)+1
//   DIV_ZERO_Q  : quotient returned for a divide by zero (all ones)
//   div_state_t : controller states IDLE / CALC / FIX
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step -- one combinational radix-2 restoring division step.
//
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor magnitude. A non-negative trial result is kept and yields a quotient
// bit of 1; otherwise the shifted value is restored and the quotient bit is 0.
//
// Ports:
//   p_in   in  WIDTH  partial remainder (unsigned, always < d_mag)
//   bit_in in  1      next dividend bit, MSB first
//   d_mag  in  WIDTH  divisor magnitude (unsigned)
//   p_out  out WIDTH  new partial remainder
//   q_bit  out 1      quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] p_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] d_mag,
    output logic [WIDTH-1:0] p_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // One extra bit beyond the WIDTH+1 shifted value makes the borrow visible
    // as the sign of the trial difference.
    assign shifted = {p_in, bit_in};
    assign trial   = {1'b0, shifted} - {2'b00, d_mag};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        p_out = shifted[WIDTH-1:0];
        q_bit = 1'b0;
        if (!trial[WIDTH+1]) begin
            p_out = trial[WIDTH-1:0];
            q_bit = 1'b1;
        end
    end

endmodule

// File: rtl/seq_div_32bit.sv
// -----------------------------------------------------------------------------
// seq_div_32bit -- sequential signed 32-bit divider (quotient + remainder).
//
// Divides the magnitudes with one restoring step per clock, then applies the
// sign correction: the quotient is negative when the operand signs differ, and
// the remainder takes the sign of the dividend. Latency is 33 edges from the
// accepting edge to done; results hold until the next done pulse.
//
// Build option: define DIV_ZERO_FAST_EN to skip the iterations when B == 0
// (done one edge after acceptance). Results are identical either way.
//
// Ports:
//   clk         in  1      rising-edge clock
//   rst_n       in  1      asynchronous active-low reset
//   start       in  1      request, sampled only while idle
//   A           in  WIDTH  dividend, two's complement
//   B           in  WIDTH  divisor, two's complement
//   busy        out 1      high from accepting edge until results are written
//   done        out 1      one-cycle pulse, results valid from this cycle
//   Quotient    out WIDTH  signed quotient, truncated toward zero
//   Remainder   out WIDTH  signed remainder, sign of the dividend
//   div_by_zero out 1      B was zero; held until the next accepted start
// -----------------------------------------------------------------------------
module seq_div_32bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state;
    logic             s_a;
    logic             s_b;
    logic             b_zero;
    logic [WIDTH-1:0] p_mag;     // partial remainder
    logic [WIDTH-1:0] q_mag;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_mag;     // divisor magnitude
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_p;
    logic             step_q;
    logic [WIDTH-1:0] rem_mag;

    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude 2^(WIDTH-1).
    assign a_mag = A[WIDTH-1] ? -A : A;
    assign b_mag = B[WIDTH-1] ? -B : B;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_in   (p_mag),
        .bit_in (q_mag[WIDTH-1]),
        .d_mag  (d_mag),
        .p_out  (step_p),
        .q_bit  (step_q)
    );

    // Divide by zero must return Remainder = A. When the iterations run, a zero
    // divisor never subtracts anything, so the partial remainder ends as |A|.
    // When they are skipped, |A| is still sitting untouched in q_mag.
`ifdef DIV_ZERO_FAST_EN
    assign rem_mag = b_zero ? q_mag : p_mag;
`else
    assign rem_mag = p_mag;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the block order cannot create races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            s_a         <= 1'b0;
            s_b         <= 1'b0;
            b_zero      <= 1'b0;
            p_mag       <= '0;
            q_mag       <= '0;
            d_mag       <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        s_a         <= A[WIDTH-1];
                        s_b         <= B[WIDTH-1];
                        b_zero      <= (B == '0);
                        q_mag       <= a_mag;
                        d_mag       <= b_mag;
                        p_mag       <= '0;
                        cnt         <= CNT_W'(WIDTH);
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
                        state       <= (B == '0) ? FIX : CALC;
`else
                        state       <= CALC;
`endif
                    end
                end

                CALC: begin
                    p_mag <= step_p;
                    q_mag <= {q_mag[WIDTH-2:0], step_q};
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    if (b_zero) begin
                        Quotient    <= DIV_ZERO_Q;
                        div_by_zero <= 1'b1;
                    end else begin
                        Quotient    <= (s_a ^ s_b) ? -q_mag : q_mag;
                    end
                    Remainder <= s_a ? -rem_mag : rem_mag;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
